// File: rtl/wb_ooo_slave_pkg.sv
// Shared types, constants and helpers for the out-of-order Wishbone slave.
// Bus widths are fixed here because the slot struct and the interface both depend on them.
package wb_ooo_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int TAG_W          = 4;
    localparam int SEL_W          = DATA_W / 8;
    localparam int CNT_W          = 3;
    localparam int DEPTH_DFLT     = 4;
    localparam int MEM_WORDS_DFLT = 16;

    // One outstanding request, parked until its countdown expires and it wins arbitration.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              err;
        logic [CNT_W-1:0]  cnt;
    } slot_t;

    // Completion latency selected by ADR_I[3:2]: 1 + 2*n, i.e. 1, 3, 5 or 7.
    function automatic logic [CNT_W-1:0] slot_latency(input logic [1:0] adr_3_2);
        return {adr_3_2, 1'b1};
    endfunction

endpackage

// File: rtl/wb_ooo_slave_if.sv
// Wishbone request/response bundle between the interconnect (master) and the slave endpoint.
interface wb_ooo_slave_if;
    import wb_ooo_pkg::*;

    logic              CYC_I;
    logic              STB_I;
    logic              WE_I;
    logic [ADDR_W-1:0] ADR_I;
    logic [DATA_W-1:0] DAT_I;
    logic [SEL_W-1:0]  SEL_I;
    logic [TAG_W-1:0]  TGA_I;
    logic              ACK_O;
    logic              RTY_O;
    logic              RESP_O;
    logic              ERR_O;
    logic [DATA_W-1:0] DAT_O;
    logic [TAG_W-1:0]  TGD_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I,
        input  ACK_O, RTY_O, RESP_O, ERR_O, DAT_O, TGD_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I,
        output ACK_O, RTY_O, RESP_O, ERR_O, DAT_O, TGD_O
    );

endinterface

// File: rtl/wb_ooo_slave_slot_pick.sv
// Find-first-set over N request bits: lowest set index wins.
module wb_ooo_slot_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_ooo_slave.sv
// Wishbone slave: acknowledges tagged requests on acceptance and returns completions
// out of order from a small slot buffer, one RESP_O pulse per completion.
module wb_ooo_slave
    import wb_ooo_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DFLT,
    parameter int MEM_WORDS = MEM_WORDS_DFLT
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    wb_ooo_slave_if.slave wb
);

    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = $clog2(MEM_WORDS);

    slot_t             r_slot [DEPTH];
    logic [DATA_W-1:0] r_mem  [MEM_WORDS];
    logic              r_ack;
    logic              r_rty;
    logic              r_resp;
    logic              r_err;
    logic [DATA_W-1:0] r_dat;
    logic [TAG_W-1:0]  r_tgd;

    logic [DEPTH-1:0]  w_free;
    logic [DEPTH-1:0]  w_ready;
    logic [SLOT_W-1:0] w_alloc_idx;
    logic [SLOT_W-1:0] w_resp_idx;
    logic              w_alloc_found;
    logic              w_resp_found;
    logic              w_req;
    logic              w_accept;
    logic              w_oor;
    logic              w_write;
    logic [WIDX_W-1:0] w_widx;
    slot_t             w_new_slot;
    logic [1:0]        w_unused;

    // While ACK_O/RTY_O is high the held strobe belongs to the request just answered.
    assign w_req    = wb.CYC_I & wb.STB_I & ~r_ack & ~r_rty;
    assign w_accept = w_req & w_alloc_found;
    assign w_widx   = wb.ADR_I[WIDX_W+1:2];
    assign w_oor    = |wb.ADR_I[ADDR_W-1:WIDX_W+2];
    assign w_write  = w_accept & wb.WE_I & ~w_oor;
    assign w_unused = wb.ADR_I[1:0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i]  = ~r_slot[i].valid;
            w_ready[i] = r_slot[i].valid && (r_slot[i].cnt == '0);
        end
    end

    always_comb begin
        w_new_slot       = '0;
        w_new_slot.valid = 1'b1;
        w_new_slot.tag   = wb.TGA_I;
        w_new_slot.err   = w_oor;
        w_new_slot.cnt   = w_oor ? CNT_W'(1) : slot_latency(wb.ADR_I[3:2]);
        if (!w_oor && !wb.WE_I) begin
            w_new_slot.data = r_mem[w_widx];
        end
    end

    wb_ooo_slot_pick #(.N(DEPTH), .IDX_W(SLOT_W)) u_alloc_pick (
        .i_req   (w_free),
        .o_idx   (w_alloc_idx),
        .o_found (w_alloc_found)
    );

    wb_ooo_slot_pick #(.N(DEPTH), .IDX_W(SLOT_W)) u_resp_pick (
        .i_req   (w_ready),
        .o_idx   (w_resp_idx),
        .o_found (w_resp_found)
    );

    // Allocation sees pre-edge valid bits, so a slot freed at this edge is not reused here.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_ack  <= 1'b0;
            r_rty  <= 1'b0;
            r_resp <= 1'b0;
            r_err  <= 1'b0;
            r_dat  <= '0;
            r_tgd  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every read here sees pre-edge state, independent of statement order.
            r_ack  <= w_accept;
            r_rty  <= w_req & ~w_alloc_found;
            r_resp <= w_resp_found;
            if (w_resp_found) begin
                r_tgd <= r_slot[w_resp_idx].tag;
                r_dat <= r_slot[w_resp_idx].data;
                r_err <= r_slot[w_resp_idx].err;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (r_slot[i].valid && (r_slot[i].cnt != '0)) begin
                    r_slot[i].cnt <= r_slot[i].cnt - CNT_W'(1);
                end
            end
            if (w_resp_found) begin
                r_slot[w_resp_idx].valid <= 1'b0;
            end
            if (w_accept) begin
                r_slot[w_alloc_idx] <= w_new_slot;
            end
        end
    end

    // NOTE: the word memory is reset on purpose; reads after reset must return zero.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_write) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb.SEL_I[b]) begin
                    r_mem[w_widx][8*b +: 8] <= wb.DAT_I[8*b +: 8];
                end
            end
        end
    end

    assign wb.ACK_O  = r_ack;
    assign wb.RTY_O  = r_rty;
    assign wb.RESP_O = r_resp;
    assign wb.ERR_O  = r_err;
    assign wb.DAT_O  = r_dat;
    assign wb.TGD_O  = r_tgd;

endmodule

// File: tb/tb_wb_ooo_slave.sv
// Scoreboard bench for wb_ooo_slave: requests push expected completions, the monitor
// pops them when RESP_O fires and checks the cycle, slot priority and payload.
`timescale 1ns/1ps
module tb_wb_ooo_slave;
    import wb_ooo_pkg::*;

    localparam int NSLOT = DEPTH_DFLT;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              err;
        int                ready;
        int                slot;
    } exp_t;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;

    wb_ooo_slave_if wb();

    wb_ooo_slave dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .wb    (wb)
    );

    always #5 CLK_I = ~CLK_I;

    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    exp_t              sb[$];
    int                resp_log[$];
    bit                slot_busy [NSLOT];
    int                slot_freed[NSLOT];
    logic [DATA_W-1:0] mem_model [16];

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < NSLOT; i++) begin
            slot_busy[i]  = 1'b0;
            slot_freed[i] = -1;
        end
        for (int w = 0; w < 16; w++) mem_model[w] = '0;
    endtask

    // Expected responder: lowest slot among entries whose countdown has expired.
    task automatic monitor_step();
        int best  = -1;
        int bslot = NSLOT;
        foreach (sb[k]) begin
            if (sb[k].ready <= cyc && sb[k].slot < bslot) begin
                best  = k;
                bslot = sb[k].slot;
            end
        end
        check("resp_o", wb.RESP_O, best >= 0);
        if (wb.RESP_O) resp_log.push_back(int'(wb.TGD_O));
        if (best >= 0 && wb.RESP_O) begin
            check("tgd_o", wb.TGD_O, sb[best].tag);
            check("dat_o", wb.DAT_O, sb[best].data);
            check("err_o", wb.ERR_O, sb[best].err);
            slot_busy[bslot]  = 1'b0;
            slot_freed[bslot] = cyc;
            sb.delete(best);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK_I);
            #1;
            if (!RST_I) monitor_step();
        end
    end

    task automatic wb_req(input logic we, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat,
                          input logic [SEL_W-1:0] sel, input logic [TAG_W-1:0] tag, output bit acked);
        int   s;
        int   idx;
        logic oor;
        exp_t e;
        @(negedge CLK_I);
        wb.CYC_I = 1'b1;
        wb.STB_I = 1'b1;
        wb.WE_I  = we;
        wb.ADR_I = adr;
        wb.DAT_I = dat;
        wb.SEL_I = sel;
        wb.TGA_I = tag;
        @(posedge CLK_I);
        #1;
        s = -1;
        for (int i = 0; i < NSLOT; i++) begin
            if (s < 0 && !slot_busy[i] && slot_freed[i] != cyc) s = i;
        end
        acked = wb.ACK_O;
        check("ack_o", wb.ACK_O, s >= 0);
        check("rty_o", wb.RTY_O, s < 0);
        if (s >= 0) begin
            oor     = |adr[ADDR_W-1:6];
            idx     = int'(adr[5:2]);
            e.tag   = tag;
            e.err   = oor;
            e.slot  = s;
            e.ready = cyc + 1 + (oor ? 1 : 1 + 2 * int'(adr[3:2]));
            e.data  = (oor || we) ? '0 : mem_model[idx];
            if (!oor && we) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (sel[b]) mem_model[idx][8*b +: 8] = dat[8*b +: 8];
                end
            end
            sb.push_back(e);
            slot_busy[s] = 1'b1;
        end
        // Strobe is still held here; it must not be taken as a second request.
        @(posedge CLK_I);
        #1;
        check("ack_pulse", wb.ACK_O, 1'b0);
        check("rty_pulse", wb.RTY_O, 1'b0);
        wb.STB_I = 1'b0;
        wb.CYC_I = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge CLK_I);
            n++;
        end
        repeat (2) @(posedge CLK_I);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ack"},  wb.ACK_O,  1'b0);
        check({pfx, "_rty"},  wb.RTY_O,  1'b0);
        check({pfx, "_resp"}, wb.RESP_O, 1'b0);
        check({pfx, "_err"},  wb.ERR_O,  1'b0);
        check({pfx, "_dat"},  wb.DAT_O,  '0);
        check({pfx, "_tgd"},  wb.TGD_O,  '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        int n_ack;
        wb.CYC_I = 1'b0;
        wb.STB_I = 1'b0;
        wb.WE_I  = 1'b0;
        wb.ADR_I = '0;
        wb.DAT_I = '0;
        wb.SEL_I = '0;
        wb.TGA_I = '0;
        clear_model();

        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        check_outputs_zero("reset");
        @(negedge CLK_I);
        RST_I = 1'b0;

        // Write then read back, plus a partial-lane write.
        wb_req(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 4'd3, a);
        wb_req(1'b0, 32'h04, 32'h0,        4'h0, 4'd5, a);
        wb_req(1'b1, 32'h08, 32'h11223344, 4'h5, 4'd6, a);
        wb_req(1'b0, 32'h08, 32'h0,        4'hF, 4'd4, a);
        drain();

        // Long read issued first completes after a short one.
        resp_log.delete();
        wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'd1, a);
        wb_req(1'b0, 32'h00, 32'h0, 4'hF, 4'd2, a);
        drain();
        check("ooo_first",  resp_log.size() > 0 ? resp_log[0] : -1, 2);
        check("ooo_second", resp_log.size() > 1 ? resp_log[1] : -1, 1);

        // Buffer full: fifth request refused, retry after first completion accepted.
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'(i), a);
            n_ack += int'(a);
        end
        check("full_ack_count", n_ack, 4);
        check("fifth_refused", a, 1'b0);
        wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'd4, a);
        check("retry_acked", a, 1'b1);
        drain();

        // Out-of-range address.
        wb_req(1'b0, 32'h100, 32'h0, 4'hF, 4'd7, a);
        drain();

        // Two slots expiring on the same edge: lower slot first.
        resp_log.delete();
        wb_req(1'b0, 32'h04, 32'h0, 4'hF, 4'd10, a);
        wb_req(1'b0, 32'h00, 32'h0, 4'hF, 4'd11, a);
        drain();
        check("tie_first",  resp_log.size() > 0 ? resp_log[0] : -1, 10);
        check("tie_second", resp_log.size() > 1 ? resp_log[1] : -1, 11);

        // Asynchronous reset with three requests outstanding.
        wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'd12, a);
        wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'd13, a);
        wb_req(1'b0, 32'h0C, 32'h0, 4'hF, 4'd14, a);
        #3;
        RST_I = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        clear_model();
        @(posedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (12) @(posedge CLK_I);
        wb_req(1'b0, 32'h04, 32'h0, 4'hF, 4'd15, a);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
